pulse_burst_sequencer: RTL and testbench

//  Automates repeated pulse injection for threshold and offset scans. Sits between the serial register block and

---
 rtl/pulse_burst_sequencer_pkg.sv | 21 ++
 rtl/pulse_burst_sequencer_sat_counter.sv | 23 ++
 rtl/pulse_burst_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_pulse_burst_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_burst_sequencer_pkg.sv
// Shared definitions for the pulse burst sequencer: widths, timeout default, FSM encodings.
package pulse_burst_sequencer_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned GAP_W_DEF   = 8;
    localparam int unsigned HS_W_DEF    = 32;
    localparam int unsigned TMO_CYC_DEF = 1023;

    // 3-bit encodings, also used by the serial block for state readback
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_FIRE    = 3'd2,
        S_WAIT_LO = 3'd3,
        S_WAIT_HI = 3'd4,
        S_EVAL    = 3'd5,
        S_GAP     = 3'd6,
        S_DONE    = 3'd7
    } state_t;

endpackage

// File: rtl/pulse_burst_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    // Clear wins over increment; increment stops at all-ones
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pulse_burst_sequencer.sv
// Repeats pulse injection, handshakes with the injector and tallies masked compare results.
module pulse_burst_sequencer
    import pulse_burst_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned GAP_W   = GAP_W_DEF,
    parameter int unsigned HS_W    = HS_W_DEF,
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic             pulser_ready,
    input  logic [HS_W-1:0]  halfstrips_last,
    input  logic [HS_W-1:0]  halfstrips_expect,
    input  logic [HS_W-1:0]  active_strip_mask,
    output logic             fire_pulse,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] pulses_sent,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_lat;
    logic [GAP_W-1:0] gap_lat, gap_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             abort_pend;

    logic accept, tmo_reload, gap_load, set_tmo, pend_set;
    logic inc_sent, inc_match, inc_mis;
    logic tmo_hit, hs_equal;

    assign tmo_hit  = (tmo_cnt == TMO_W'(TMO_CYC - 1));
    assign hs_equal = (((halfstrips_last ^ halfstrips_expect) & active_strip_mask) == '0);

    // State register and registered strobes/status
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            fire_pulse <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            fire_pulse <= (state_nxt == S_FIRE);
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        tmo_reload = 1'b0;
        gap_load   = 1'b0;
        set_tmo    = 1'b0;
        pend_set   = 1'b0;
        inc_sent   = 1'b0;
        inc_match  = 1'b0;
        inc_mis    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    tmo_reload = 1'b1;
                    state_nxt  = (num_pulses == '0) ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else if (pulser_ready) begin
                    state_nxt = S_FIRE;
                end else if (tmo_hit) begin
                    set_tmo   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_FIRE: begin
                inc_sent   = 1'b1;
                pend_set   = abort;
                tmo_reload = 1'b1;
                state_nxt  = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                pend_set = abort;
                if (!pulser_ready) begin
                    tmo_reload = 1'b1;
                    state_nxt  = S_WAIT_HI;
                end else if (tmo_hit) begin
                    set_tmo   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_WAIT_HI: begin
                pend_set = abort;
                if (pulser_ready) begin
                    state_nxt = S_EVAL;
                end else if (tmo_hit) begin
                    set_tmo   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_EVAL: begin
                inc_match = hs_equal;
                inc_mis   = !hs_equal;
                if ((pulses_sent == num_lat) || abort_pend || abort) begin
                    state_nxt = S_DONE;
                end else begin
                    gap_load  = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_nxt = S_DONE;
                end else if (gap_cnt <= GAP_W'(1)) begin
                    tmo_reload = 1'b1;
                    state_nxt  = S_ARM;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Burst parameters, pending abort and sticky timeout
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            num_lat    <= '0;
            gap_lat    <= '0;
            abort_pend <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (accept) begin
                num_lat    <= num_pulses;
                gap_lat    <= gap_cycles;
                abort_pend <= 1'b0;
                timeout    <= 1'b0;
            end else begin
                if (pend_set) begin
                    abort_pend <= 1'b1;
                end
                if (set_tmo) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

    // Shared handshake timeout counter and inter-pulse gap counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (tmo_reload) begin
                tmo_cnt <= '0;
            end else if (!tmo_hit) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (gap_load) begin
                gap_cnt <= gap_lat;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_sent (
        .clock (clock),
        .reset (reset),
        .inc   (inc_sent),
        .clr   (accept),
        .q     (pulses_sent)
    );

    sat_counter #(.W(CNT_W)) u_match (
        .clock (clock),
        .reset (reset),
        .inc   (inc_match),
        .clr   (accept),
        .q     (match_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mismatch (
        .clock (clock),
        .reset (reset),
        .inc   (inc_mis),
        .clr   (accept),
        .q     (mismatch_cnt)
    );

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Bench for pulse_burst_sequencer: injector model plus transaction-level expected counts.
module tb_pulse_burst_sequencer;

    localparam int TMO = 1023;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] num_pulses;
    logic [7:0]  gap_cycles;
    logic        pulser_ready;
    logic [31:0] halfstrips_last;
    logic [31:0] halfstrips_expect;
    logic [31:0] active_strip_mask;
    logic        fire_pulse;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] pulses_sent;
    logic [15:0] match_cnt;
    logic [15:0] mismatch_cnt;

    pulse_burst_sequencer dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .num_pulses        (num_pulses),
        .gap_cycles        (gap_cycles),
        .pulser_ready      (pulser_ready),
        .halfstrips_last   (halfstrips_last),
        .halfstrips_expect (halfstrips_expect),
        .active_strip_mask (active_strip_mask),
        .fire_pulse        (fire_pulse),
        .busy              (busy),
        .done              (done),
        .timeout           (timeout),
        .pulses_sent       (pulses_sent),
        .match_cnt         (match_cnt),
        .mismatch_cnt      (mismatch_cnt)
    );

    always #5 clock = ~clock;

    // Injector model controls (written only by the stimulus block)
    int          drop_dly  = 2;
    int          low_len   = 8;
    bit          stuck_low = 1'b0;
    int          inj_clr_req = 0;
    logic [31:0] res_arr [0:127];

    // Injector model state (written only by the injector process)
    int inj_clr_ack  = 0;
    int inj_phase    = 0;
    int inj_t        = 0;
    int res_idx      = 0;
    int fire_total   = 0;
    int done_seen    = 0;
    int cyc          = 0;
    int last_fire_cyc = 0;
    int last_done_cyc = 0;

    int n_pass  = 0;
    int n_total = 0;
    int d0, f0;

    // Injector: accept fire, drop ready after drop_dly, hold low low_len, then present result
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            inj_phase    = 0;
            res_idx      = 0;
            pulser_ready = 1'b1;
        end else begin
            if (done) begin
                done_seen++;
                last_done_cyc = cyc;
            end
            if (fire_pulse) begin
                fire_total++;
                last_fire_cyc = cyc;
            end
            if (inj_clr_req != inj_clr_ack) begin
                inj_clr_ack  = inj_clr_req;
                inj_phase    = 0;
                res_idx      = 0;
                pulser_ready = 1'b1;
            end else begin
                case (inj_phase)
                    0: if (fire_pulse) begin
                        inj_phase = 1;
                        inj_t     = 0;
                    end
                    1: begin
                        inj_t++;
                        if (inj_t >= drop_dly) begin
                            pulser_ready = 1'b0;
                            inj_phase    = 2;
                            inj_t        = 0;
                        end
                    end
                    2: begin
                        inj_t++;
                        if (!stuck_low && inj_t >= low_len) begin
                            halfstrips_last = res_arr[res_idx];
                            res_idx++;
                            pulser_ready = 1'b1;
                            inj_phase    = 0;
                        end
                    end
                    default: inj_phase = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected counts from the masked-compare rule over the first n results
    task automatic model_counts(input int n, output int m, output int mm);
        m = 0;
        mm = 0;
        for (int i = 0; i < n; i++) begin
            if (((res_arr[i] ^ halfstrips_expect) & active_strip_mask) == 32'h0) m++;
            else mm++;
        end
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (done_seen != d0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic kick(input int n, input int g);
        inj_clr_req++;
        tick();
        d0 = done_seen;
        f0 = fire_total;
        num_pulses = 16'(n);
        gap_cycles = 8'(g);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_burst(input string tag, input int n, input int budget);
        logic ok;
        int   m, mm;
        wait_done(budget, ok);
        check({tag, "_done_seen"}, 32'(ok), 32'd1);
        tick();
        model_counts(n, m, mm);
        check({tag, "_sent"}, 32'(pulses_sent), 32'(n));
        check({tag, "_fires"}, 32'(fire_total - f0), 32'(n));
        check({tag, "_match"}, 32'(match_cnt), 32'(m));
        check({tag, "_mismatch"}, 32'(mismatch_cnt), 32'(mm));
        check({tag, "_one_done"}, 32'(done_seen - d0), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
        check({tag, "_no_tmo"}, 32'(timeout), 32'd0);
    endtask

    initial begin
        logic ok;
        int   n, g, m, mm, diff, guard;

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_pulses = '0;
        gap_cycles = '0;
        halfstrips_last   = '0;
        halfstrips_expect = 32'h1234_5678;
        active_strip_mask = 32'hFFFF_FFFF;
        for (int i = 0; i < 128; i++) res_arr[i] = 32'h1234_5678;
        tick();
        tick();

        // Reset state
        check("rst_fire", 32'(fire_pulse), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tmo", 32'(timeout), 32'd0);
        check("rst_sent", 32'(pulses_sent), 32'd0);
        check("rst_match", 32'(match_cnt), 32'd0);
        check("rst_mis", 32'(mismatch_cnt), 32'd0);
        reset = 1'b1;
        tick();

        // Five pulses, results equal expect; also start->fire latency with ready high
        kick(5, 3);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_fire_early", 32'(fire_pulse), 32'd0);
        tick();
        check("lat_fire", 32'(fire_pulse), 32'd1);
        check_burst("t1", 5, 500);

        // Mask 0xF: bit 8 always differs (ignored), bit 2 differs on pulse 3
        active_strip_mask = 32'h0000_000F;
        halfstrips_expect = 32'hA5A5_0000;
        for (int i = 0; i < 4; i++) res_arr[i] = 32'hA5A5_0100;
        res_arr[2] = 32'hA5A5_0104;
        kick(4, 1);
        check_burst("t2", 4, 500);
        check("t2_fixed_match", 32'(match_cnt), 32'd3);
        check("t2_fixed_mis", 32'(mismatch_cnt), 32'd1);

        // Zero pulses: straight to done, nothing fired
        kick(0, 5);
        check("t3_done", 32'(done), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        tick();
        check("t3_done_low", 32'(done), 32'd0);
        check("t3_busy_low", 32'(busy), 32'd0);
        check("t3_fires", 32'(fire_total - f0), 32'd0);
        check("t3_sent", 32'(pulses_sent), 32'd0);
        check("t3_match", 32'(match_cnt), 32'd0);

        // Ready stuck low after first fire -> handshake timeout
        stuck_low = 1'b1;
        drop_dly  = 2;
        kick(3, 2);
        wait_done(TMO + 200, ok);
        check("t4_done_seen", 32'(ok), 32'd1);
        diff = last_done_cyc - last_fire_cyc;
        check("t4_tmo_window", 32'((diff >= TMO) && (diff <= TMO + drop_dly + 2)), 32'd1);
        tick();
        check("t4_tmo", 32'(timeout), 32'd1);
        check("t4_sent", 32'(pulses_sent), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        stuck_low = 1'b0;

        // Next accepted start clears the sticky timeout
        active_strip_mask = 32'hFFFF_FFFF;
        halfstrips_expect = 32'h0;
        for (int i = 0; i < 128; i++) res_arr[i] = (i % 3 == 0) ? 32'h0000_0010 : 32'h0;
        kick(2, 0);
        check("t4_tmo_clr", 32'(timeout), 32'd0);
        check_burst("t4b", 2, 500);

        // Abort during WAIT_HI of pulse 7 of a long burst
        kick(100, 2);
        guard = 0;
        while (!((fire_total - f0 == 7) && (inj_phase == 2) && (inj_t >= 2)) && guard < 3000) begin
            tick();
            guard++;
        end
        check("t5_reach_p7", 32'(guard < 3000), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_burst("t5", 7, 500);

        // Async reset while fire_pulse is high on pulse 2
        kick(4, 1);
        guard = 0;
        while (!(fire_pulse && (fire_total - f0 == 2)) && guard < 500) begin
            tick();
            guard++;
        end
        check("t6_reach_fire", 32'(fire_pulse), 32'd1);
        check("t6_sent_pre", 32'(pulses_sent), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_fire_async", 32'(fire_pulse), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_sent", 32'(pulses_sent), 32'd0);
        check("t6_match", 32'(match_cnt), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        kick(3, 2);
        check_burst("t6b", 3, 500);

        // Start and abort together in IDLE: start wins
        inj_clr_req++;
        tick();
        d0 = done_seen;
        f0 = fire_total;
        num_pulses = 16'd2;
        gap_cycles = 8'd0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_burst("t7", 2, 500);

        // Randomized bursts
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 9));
            g = int'($urandom_range(0, 5));
            drop_dly = int'($urandom_range(1, 3));
            low_len  = int'($urandom_range(1, 6));
            halfstrips_expect = $urandom;
            active_strip_mask = $urandom;
            for (int i = 0; i < 16; i++)
                res_arr[i] = ($urandom_range(0, 1) == 1) ? halfstrips_expect : (halfstrips_expect ^ $urandom);
            kick(n, g);
            check_burst("rnd", n, 100 * n + 100);
        end

        model_counts(0, m, mm);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
